// File: rtl/step_scheduler_if.sv
// Request/step bundle between the board inputs and the step scheduler.
// master drives the raw pins and observes the step outputs; slave is the scheduler side.
interface step_scheduler_if;
  logic UP_REQ;
  logic DN_REQ;
  logic BTN_UP;
  logic BTN_DN;
  logic STEP;
  logic DIR;
  logic FAULT;
  logic RUN;

  modport master (
    output UP_REQ, DN_REQ, BTN_UP, BTN_DN,
    input  STEP, DIR, FAULT, RUN
  );

  modport slave (
    input  UP_REQ, DN_REQ, BTN_UP, BTN_DN,
    output STEP, DIR, FAULT, RUN
  );
endinterface

// File: rtl/step_scheduler.sv
// Turns switch levels and pushbutton presses into one-cycle STEP enables plus DIR for the ring FSM.
// Pin-to-STEP latency is 3 edges; button steps take priority over auto-run ticks, which are dropped.
module step_scheduler #(
  parameter int DIV_MAX = 50000000,
  parameter int CW      = 26
) (
  input  logic             CLOCK50,
  input  logic             RESET_N,
  step_scheduler_if.slave  sched
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_UP = 2'd1,
    ST_RUN_DN = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  logic r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
  logic r_bu_s1, r_bu_s2, r_bu_d;
  logic r_bd_s1, r_bd_s2, r_bd_d;

  state_t          r_state;
  state_t          w_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_step, r_dir, r_fault, r_run;
  logic            w_step, w_dir;
  logic            w_ev_up, w_ev_dn, w_in_run, w_tick;

  // Switches idle low, buttons idle high, so reset never fabricates a press edge.
  always_ff @(posedge CLOCK50) begin
    if (!RESET_N) begin
      r_up_s1 <= 1'b0;
      r_up_s2 <= 1'b0;
      r_dn_s1 <= 1'b0;
      r_dn_s2 <= 1'b0;
      r_bu_s1 <= 1'b1;
      r_bu_s2 <= 1'b1;
      r_bu_d  <= 1'b1;
      r_bd_s1 <= 1'b1;
      r_bd_s2 <= 1'b1;
      r_bd_d  <= 1'b1;
    end else begin
      r_up_s1 <= sched.UP_REQ;
      r_up_s2 <= r_up_s1;
      r_dn_s1 <= sched.DN_REQ;
      r_dn_s2 <= r_dn_s1;
      r_bu_s1 <= sched.BTN_UP;
      r_bu_s2 <= r_bu_s1;
      r_bu_d  <= r_bu_s2;
      r_bd_s1 <= sched.BTN_DN;
      r_bd_s2 <= r_bd_s1;
      r_bd_d  <= r_bd_s2;
    end
  end

  assign w_ev_up  = r_bu_d & ~r_bu_s2;
  assign w_ev_dn  = r_bd_d & ~r_bd_s2;
  assign w_in_run = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DN);
  assign w_tick   = w_in_run && (r_cnt == CW'(DIV_MAX - 1));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_up_s2 && r_dn_s2)  w_nxt = ST_FAULT;
        else if (r_up_s2)        w_nxt = ST_RUN_UP;
        else if (r_dn_s2)        w_nxt = ST_RUN_DN;
      end
      ST_RUN_UP: begin
        if (r_up_s2 && r_dn_s2)  w_nxt = ST_FAULT;
        else if (r_dn_s2)        w_nxt = ST_RUN_DN;
        else if (!r_up_s2)       w_nxt = ST_IDLE;
      end
      ST_RUN_DN: begin
        if (r_up_s2 && r_dn_s2)  w_nxt = ST_FAULT;
        else if (r_up_s2)        w_nxt = ST_RUN_UP;
        else if (!r_dn_s2)       w_nxt = ST_IDLE;
      end
      ST_FAULT: begin
        if (!r_up_s2 && !r_dn_s2) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Prescaler restarts on every entry into a run state, including a direct reversal.
  always_comb begin
    w_cnt_nxt = '0;
    if ((w_nxt == ST_RUN_UP || w_nxt == ST_RUN_DN) && (w_nxt == r_state)) begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_step = 1'b0;
    w_dir  = r_dir;
    if ((r_state != ST_FAULT) && (w_ev_up ^ w_ev_dn)) begin
      w_step = 1'b1;
      w_dir  = w_ev_up;
    end else if (w_tick) begin
      w_step = 1'b1;
      w_dir  = (r_state == ST_RUN_UP);
    end
  end

  always_ff @(posedge CLOCK50) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_fault <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step;
      r_dir   <= w_dir;
      r_fault <= (w_nxt == ST_FAULT);
      r_run   <= (w_nxt == ST_RUN_UP) || (w_nxt == ST_RUN_DN);
    end
  end

  assign sched.STEP  = r_step;
  assign sched.DIR   = r_dir;
  assign sched.FAULT = r_fault;
  assign sched.RUN   = r_run;

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler with DIV_MAX=4; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_step_scheduler;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  step_scheduler_if sif();

  step_scheduler #(.DIV_MAX(4), .CW(3)) dut (
    .CLOCK50 (clk),
    .RESET_N (rst_n),
    .sched   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n cycles, tallying STEP pulses, the first pulse offset and pulses per direction.
  task automatic watch(input int n, output int cnt, output int first, output int n_up, output int n_dn);
    cnt = 0; first = -1; n_up = 0; n_dn = 0;
    for (int i = 1; i <= n; i++) begin
      cyc(1);
      if (sif.STEP === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        if (sif.DIR === 1'b1) n_up++;
        else n_dn++;
      end
    end
  endtask

  initial begin
    int cnt, first, n_up, n_dn;
    n_chk = 0;
    n_pass = 0;
    sif.UP_REQ = 1'b0;
    sif.DN_REQ = 1'b0;
    sif.BTN_UP = 1'b1;
    sif.BTN_DN = 1'b1;
    rst_n = 1'b0;
    cyc(2);
    chk("rst_step",  sif.STEP,  0);
    chk("rst_dir",   sif.DIR,   0);
    chk("rst_fault", sif.FAULT, 0);
    chk("rst_run",   sif.RUN,   0);
    rst_n = 1'b1;
    cyc(1);

    // auto-run up
    sif.UP_REQ = 1'b1;
    cyc(2);
    chk("t1_run_edge2", sif.RUN, 0);
    cyc(1);
    chk("t1_run_edge3", sif.RUN, 1);
    watch(20, cnt, first, n_up, n_dn);
    chk("t1_first", first, 4);
    chk("t1_pulses", cnt, 5);
    chk("t1_dn_pulses", n_dn, 0);

    // reversal straight into RUN_DN
    sif.UP_REQ = 1'b0;
    sif.DN_REQ = 1'b1;
    watch(7, cnt, first, n_up, n_dn);
    chk("t2_up_pulses", n_up, 0);
    chk("t2_pulses", cnt, 1);
    chk("t2_first", first, 7);
    chk("t2_dir", sif.DIR, 0);
    chk("t2_run", sif.RUN, 1);

    // both levels -> fault
    sif.UP_REQ = 1'b1;
    watch(3, cnt, first, n_up, n_dn);
    chk("t3_entry_steps", cnt, 0);
    chk("t3_fault", sif.FAULT, 1);
    chk("t3_run", sif.RUN, 0);
    sif.BTN_UP = 1'b0;
    watch(6, cnt, first, n_up, n_dn);
    chk("t3_btn_ignored", cnt, 0);
    sif.BTN_UP = 1'b1;
    sif.DN_REQ = 1'b0;
    watch(5, cnt, first, n_up, n_dn);
    chk("t3_one_level_steps", cnt, 0);
    chk("t3_fault_held", sif.FAULT, 1);
    chk("t3_run_held", sif.RUN, 0);
    sif.UP_REQ = 1'b0;
    cyc(2);
    chk("t3_fault_edge2", sif.FAULT, 1);
    cyc(1);
    chk("t3_fault_clear", sif.FAULT, 0);
    chk("t3_idle_run", sif.RUN, 0);

    // idle button handling
    sif.BTN_DN = 1'b0;
    watch(10, cnt, first, n_up, n_dn);
    chk("t4_hold_pulses", cnt, 1);
    chk("t4_hold_first", first, 3);
    chk("t4_hold_up", n_up, 0);
    sif.BTN_DN = 1'b1;
    cyc(4);
    sif.BTN_UP = 1'b0;
    sif.BTN_DN = 1'b0;
    watch(6, cnt, first, n_up, n_dn);
    chk("t4_cancel", cnt, 0);
    sif.BTN_UP = 1'b1;
    sif.BTN_DN = 1'b1;
    cyc(4);

    // button event coinciding with a tick
    sif.UP_REQ = 1'b1;
    cyc(3);
    chk("t5_run", sif.RUN, 1);
    cyc(1);
    sif.BTN_DN = 1'b0;
    watch(2, cnt, first, n_up, n_dn);
    chk("t5_pre_steps", cnt, 0);
    cyc(1);
    chk("t5_btn_step", sif.STEP, 1);
    chk("t5_btn_dir", sif.DIR, 0);
    cyc(1);
    chk("t5_no_defer", sif.STEP, 0);
    chk("t5_dir_hold", sif.DIR, 0);
    watch(3, cnt, first, n_up, n_dn);
    chk("t5_next_first", first, 3);
    chk("t5_next_pulses", cnt, 1);
    chk("t5_next_up", n_up, 1);

    // reset mid-run at prescaler=2
    sif.BTN_DN = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    chk("t6_step", sif.STEP, 0);
    chk("t6_dir", sif.DIR, 0);
    chk("t6_fault", sif.FAULT, 0);
    chk("t6_run", sif.RUN, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("t6_step_r1", sif.STEP, 0);
    chk("t6_run_r1", sif.RUN, 0);
    cyc(1);
    chk("t6_step_r2", sif.STEP, 0);
    chk("t6_run_r2", sif.RUN, 0);
    cyc(1);
    chk("t6_run_r3", sif.RUN, 1);
    watch(4, cnt, first, n_up, n_dn);
    chk("t6_first", first, 4);
    chk("t6_pulses", cnt, 1);
    chk("t6_up", n_up, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
